// File: rtl/mdu_hilo_if.sv
// Request/response bundle between the issue stage and the HI/LO multiply-divide unit.
interface mdu_hilo_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] mdu_a_data;
  logic [DATA_W-1:0] mdu_b_data;
  logic [2:0]        mdu_op;
  logic              mdu_start;
  logic              mdu_flush;
  logic              mdu_busy;
  logic              mdu_done;
  logic [DATA_W-1:0] mdu_hi;
  logic [DATA_W-1:0] mdu_lo;

  modport master (output mdu_a_data, mdu_b_data, mdu_op, mdu_start, mdu_flush,
                  input  mdu_busy, mdu_done, mdu_hi, mdu_lo);
  modport slave  (input  mdu_a_data, mdu_b_data, mdu_op, mdu_start, mdu_flush,
                  output mdu_busy, mdu_done, mdu_hi, mdu_lo);
endinterface

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Sign-magnitude datapath: one shift-add or restoring-subtract step per CALC cycle.
module mdu_hilo #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_hilo_if.slave  bus
);
  localparam int W  = DATA_W;
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_mag, b_mag, hi_q, lo_q;
  logic [2*W-1:0]  acc, acc_nxt, prod;
  logic            is_div, neg_q, neg_r, dz;
  logic            sa, sb;
  logic [W:0]      mul_sum, rem_sh;
  logic [W+1:0]    diff;
  logic [W-1:0]    q_fix, r_fix, res_hi, res_lo;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start wins over flush in IDLE since flush only applies to CALC/DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.mdu_start && !bus.mdu_op[2]) state_nxt = CALC;
      CALC: if (bus.mdu_flush)                   state_nxt = IDLE;
            else if (cnt == CW'(W-1))            state_nxt = DONE;
      DONE:                                      state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mdu_busy = (state != IDLE);
    bus.mdu_done = (state == DONE);
  end

  assign bus.mdu_hi = hi_q;
  assign bus.mdu_lo = lo_q;

  // Operand signs only matter for the signed ops (op[0]=1)
  assign sa = bus.mdu_op[0] & bus.mdu_a_data[W-1];
  assign sb = bus.mdu_op[0] & bus.mdu_b_data[W-1];

  // One iteration: multiply shifts the partial product right, divide shifts the remainder left
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
    rem_sh  = {acc[2*W-1:W], acc[W-1]};
    diff    = {1'b0, rem_sh} - {2'b0, b_mag};
    if (is_div)
      acc_nxt = diff[W+1] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                          : {diff[W-1:0],   acc[W-2:0], 1'b1};
    else
      acc_nxt = {mul_sum, acc[W-1:1]};
  end

  // Sign fix-up; divide by zero forces an all-ones quotient, remainder is A itself
  always_comb begin
    prod   = neg_q ? -acc : acc;
    q_fix  = neg_q ? -acc[W-1:0]     : acc[W-1:0];
    r_fix  = neg_r ? -acc[2*W-1:W]   : acc[2*W-1:W];
    res_hi = is_div ? r_fix : prod[2*W-1:W];
    res_lo = is_div ? (dz ? '1 : q_fix) : prod[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.mdu_start) begin
          case (bus.mdu_op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              a_mag  <= sa ? -bus.mdu_a_data : bus.mdu_a_data;
              b_mag  <= sb ? -bus.mdu_b_data : bus.mdu_b_data;
              acc    <= bus.mdu_op[1] ? {{W{1'b0}}, (sa ? -bus.mdu_a_data : bus.mdu_a_data)}
                                      : {{W{1'b0}}, (sb ? -bus.mdu_b_data : bus.mdu_b_data)};
              is_div <= bus.mdu_op[1];
              neg_q  <= sa ^ sb;
              neg_r  <= sa;
              dz     <= bus.mdu_op[1] && (bus.mdu_b_data == '0);
              cnt    <= '0;
            end
            3'b100:  hi_q <= bus.mdu_a_data;
            3'b101:  lo_q <= bus.mdu_a_data;
            default: ;
          endcase
        end
        CALC: if (!bus.mdu_flush) begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        DONE: if (!bus.mdu_flush) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: hand-computed HI/LO results, latency, flush and reset behaviour.
module tb_mdu_hilo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_hilo_if #(.DATA_W(32)) bus ();
  mdu_hilo #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, scramble operands after acceptance, follow it until busy drops.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic flush_too, output int bcyc, output int dcnt, output int hl_chg);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = bus.mdu_hi;
    lo0 = bus.mdu_lo;
    bus.mdu_op = op; bus.mdu_a_data = a; bus.mdu_b_data = b;
    bus.mdu_start = 1'b1; bus.mdu_flush = flush_too;
    @(negedge clk);
    bus.mdu_start = 1'b0; bus.mdu_flush = 1'b0;
    bus.mdu_a_data = $urandom; bus.mdu_b_data = $urandom;
    bcyc = 0; dcnt = 0; hl_chg = 0;
    for (int i = 0; i < 100 && bus.mdu_busy; i++) begin
      bcyc++;
      if (bus.mdu_done) dcnt++;
      if (bus.mdu_hi !== hi0 || bus.mdu_lo !== lo0) hl_chg++;
      @(negedge clk);
    end
  endtask

  task automatic run_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic flush_too,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bc, dc, hc;
    do_op(op, a, b, flush_too, bc, dc, hc);
    chk({tag, "_busy_cycles"}, bc, 33);
    chk({tag, "_done_pulses"}, dc, 1);
    chk({tag, "_hilo_stable"}, hc, 0);
    chk({tag, "_hi"}, bus.mdu_hi, exp_hi);
    chk({tag, "_lo"}, bus.mdu_lo, exp_lo);
  endtask

  initial begin
    int dcnt, bcnt;
    bus.mdu_a_data = '0; bus.mdu_b_data = '0; bus.mdu_op = '0;
    bus.mdu_start = 1'b0; bus.mdu_flush = 1'b0;

    #12;
    chk("rst_busy", bus.mdu_busy, 0);
    chk("rst_done", bus.mdu_done, 0);
    chk("rst_hi", bus.mdu_hi, 0);
    chk("rst_lo", bus.mdu_lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_chk("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_chk("mult_neg",  3'b001, 32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_chk("div_neg",   3'b011, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_chk("divu_zero", 3'b010, 32'd100,      32'd0,        1'b0, 32'd100,      32'hFFFFFFFF);
    run_chk("div_ovf",   3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);
    run_chk("div_zero",  3'b011, 32'hFFFFFFFB, 32'd0,        1'b0, 32'hFFFFFFFB, 32'hFFFFFFFF);

    // mthi then mtlo on consecutive edges
    @(negedge clk);
    bus.mdu_op = 3'b100; bus.mdu_a_data = 32'h12345678; bus.mdu_start = 1'b1;
    @(negedge clk);
    chk("mthi_hi", bus.mdu_hi, 32'h12345678);
    chk("mthi_busy", bus.mdu_busy, 0);
    bus.mdu_op = 3'b101; bus.mdu_a_data = 32'h9ABCDEF0;
    @(negedge clk);
    chk("mtlo_lo", bus.mdu_lo, 32'h9ABCDEF0);
    chk("mtlo_busy", bus.mdu_busy, 0);
    // Reserved opcode is a no-op
    bus.mdu_op = 3'b110; bus.mdu_a_data = 32'hDEADBEEF;
    @(negedge clk);
    bus.mdu_start = 1'b0;
    chk("nop_busy", bus.mdu_busy, 0);
    chk("nop_hi", bus.mdu_hi, 32'h12345678);
    chk("nop_lo", bus.mdu_lo, 32'h9ABCDEF0);

    // Start with flush in IDLE is still accepted
    run_chk("flush_start", 3'b000, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);

    // divu aborted by flush; a start while busy must not be queued
    @(negedge clk);
    bus.mdu_op = 3'b100; bus.mdu_a_data = 32'h11; bus.mdu_start = 1'b1;
    @(negedge clk);
    bus.mdu_op = 3'b101; bus.mdu_a_data = 32'h22;
    @(negedge clk);
    bus.mdu_op = 3'b010; bus.mdu_a_data = 32'd1000; bus.mdu_b_data = 32'd7;
    @(negedge clk);
    bus.mdu_start = 1'b0;
    dcnt = 0;
    for (int c = 1; c < 10; c++) begin
      if (c == 3) begin bus.mdu_start = 1'b1; bus.mdu_op = 3'b000; end
      if (c == 4) bus.mdu_start = 1'b0;
      if (bus.mdu_done) dcnt++;
      @(negedge clk);
    end
    chk("flush_busy_before", bus.mdu_busy, 1);
    bus.mdu_flush = 1'b1;
    @(negedge clk);
    bus.mdu_flush = 1'b0;
    chk("flush_busy_after", bus.mdu_busy, 0);
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.mdu_done) dcnt++;
      if (bus.mdu_busy) bcnt++;
      @(negedge clk);
    end
    chk("flush_no_done", dcnt, 0);
    chk("flush_no_requeue", bcnt, 0);
    chk("flush_hi", bus.mdu_hi, 32'h11);
    chk("flush_lo", bus.mdu_lo, 32'h22);

    // Asynchronous reset in the middle of a mult
    @(negedge clk);
    bus.mdu_op = 3'b001; bus.mdu_a_data = 32'h1234; bus.mdu_b_data = 32'h5678;
    bus.mdu_start = 1'b1;
    @(negedge clk);
    bus.mdu_start = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy_before", bus.mdu_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.mdu_busy, 0);
    chk("arst_done", bus.mdu_done, 0);
    chk("arst_hi", bus.mdu_hi, 0);
    chk("arst_lo", bus.mdu_lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk("post_rst_multu", 3'b000, 32'd3, 32'd5, 1'b0, 32'd0, 32'd15);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 Parameter: DATA_W, default 32, operand and HI/LO register width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: mdu_a_data  input  32  operand A (rs); dividend or multiplicand.
REQ-005 Port: mdu_b_data  input  32  operand B (rt); divisor or multiplier.
REQ-006 Port: mdu_op  input  3  000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo; others are no-op.
REQ-007 Port: mdu_start  input  1  request; sampled only while mdu_busy=0.
REQ-008 Port: mdu_flush  input  1  cancels an in-flight operation.
REQ-009 Port: mdu_busy  output  1  high while state is not IDLE.
REQ-010 Port: mdu_done  output  1  one-cycle pulse in DONE state.
REQ-011 Port: mdu_hi  output  32  HI register (product upper word / remainder).
REQ-012 Port: mdu_lo  output  32  LO register (product lower word / quotient).

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; mdu_busy = (state != IDLE); mdu_done = (state == DONE).
REQ-014 IDLE, start=1, op in {000..011}: latch operand magnitudes, signs and op; clear iteration counter; go to CALC.
REQ-015 IDLE, start=1, op 100/101: write mdu_a_data into HI/LO at that edge; stay IDLE; no busy, no done.
REQ-016 IDLE, start=1, op 110/111: no state change, no register change.
REQ-017 CALC: exactly one radix-2 iteration per cycle (shift-add multiply, restoring divide) on 32-bit magnitudes; after the 32nd iteration go to DONE.
REQ-018 DONE: apply sign fix-up, write HI/LO at the edge leaving DONE, go to IDLE.
REQ-019 Latency: start accepted at edge E0; CALC during cycles after E1..E32; mdu_done high between E32 and E33; new HI/LO visible after E33.
REQ-020 mdu_start while busy SHALL be ignored, not queued.
REQ-021 Signed ops: operate on |A|, |B|; negate the product if sign(A)^sign(B); negate the quotient if sign(A)^sign(B); the remainder takes sign(A).
REQ-022 mult/multu result SHALL be the exact 64-bit product: HI = [63:32], LO = [31:0].
REQ-023 Divide by zero (B=0, div or divu): LO = 0xFFFFFFFF, HI = A unchanged; full latency still applies.
REQ-024 div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000; no trap.
REQ-025 HI/LO SHALL NOT change during CALC; operand inputs may change after E0 without effect.
REQ-026 mdu_flush=1 in CALC or DONE: go to IDLE at the next edge, no HI/LO write, no done pulse; flush in IDLE is a no-op.
REQ-027 Simultaneous flush and start in IDLE: the start is accepted and flush is ignored.

Reset
REQ-028 rst_n low SHALL force state IDLE, HI = 0, LO = 0, counter = 0, mdu_busy = 0, mdu_done = 0, immediately and independent of clk.
REQ-029 Reset asserted mid-CALC SHALL abandon the operation; after release the block accepts a new start on the first edge.

Verification
REQ-030 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> busy for 33 cycles, done once; HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 mult A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-032 div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu A=100, B=0 -> LO=0xFFFFFFFF, HI=100.
REQ-033 mthi A=0x12345678, then mtlo A=0x9ABCDEF0 back-to-back -> HI/LO updated on the next edges, busy stays 0.
REQ-034 divu started with HI/LO=0x11/0x22; new start while busy, flush at cycle 10 -> no done; HI/LO stay 0x11/0x22; busy low after flush edge.
REQ-035 rst_n pulsed low at cycle 15 of a mult -> HI=LO=0, busy=0 asynchronously; the next multu 3x5 gives LO=15, HI=0.
